instr_mem_loader: RTL and testbench
===================================

# instr_mem_loader

Boot-time controller that fills the instruction memory from a byte-serial stream (UART receiver or debug port) and holds the core in reset until the program is resident. It receives a 16-bit word count and then the program bytes. It packs the bytes into little-endian 32-bit words and issues one write per word to the instruction memory write port at byte addresses 0, 4, 8, and so on. The fetch unit reads those addresses with word index addr>>2. The block sits between the host link and the instruction memory, next to the core's reset logic.

## Interface
- WIDTH, 32: instruction word width and memory address width.
- DEPTH, 8: log2 of the instruction memory size in words. The memory holds 2**DEPTH = 256 words.
- clk  in  1  system clock; all logic is on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- start  in  1  single-cycle pulse that begins a load.
- rx_data  in  8  incoming byte.
- rx_valid  in  1  rx_data is valid.
- rx_ready  out  1  the block can accept a byte this cycle.
- mem_we  out  1  instruction memory write enable.
- mem_waddr  out  WIDTH  byte address of the write; always word-aligned.
- mem_wdata  out  WIDTH  instruction word to write.
- cpu_hold  out  1  high keeps the core in reset or stall.
- done  out  1  the load completed successfully.
- err  out  1  the length header was invalid.
- word_cnt  out  DEPTH+1  number of words written in the current load.

## Operation
- FSM states: IDLE, LEN0, LEN1, DATA, WRITE, DONE, ERR. All outputs are registered or decoded from state (Moore).
- A byte is consumed on a clock edge where rx_valid and rx_ready are both 1. rx_ready is 1 only in LEN0, LEN1 and DATA.
- IDLE: start moves to LEN0.
- LEN0: consuming a byte stores the length low byte and moves to LEN1.
- LEN1: consuming a byte sets len = {byte, low byte}.
  - If len == 0 or len > 2**DEPTH, go to ERR.
  - Otherwise clear word_cnt, mem_waddr and the byte index, then go to DATA.
- DATA: byte k (k = 0..3) is written to mem_wdata[8k+7:8k]. Consuming byte 3 moves to WRITE.
- WRITE: lasts one cycle. mem_we = 1 and rx_ready = 0.
  - On exit, mem_waddr increases by 4 and word_cnt by 1.
  - If the new word_cnt == len, go to DONE; otherwise return to DATA.
- DONE: done = 1 and cpu_hold = 0. start moves to LEN0, which clears done and re-asserts cpu_hold.
- ERR: err = 1 and cpu_hold = 1. start moves to LEN0 and clears err.
- start is ignored in LEN0, LEN1, DATA and WRITE.
- cpu_hold is 0 only in DONE.
- Reset values: state IDLE, rx_ready 0, mem_we 0, mem_waddr 0, mem_wdata 0, cpu_hold 1, done 0, err 0, word_cnt 0.
- Reset during a load: the block returns to IDLE with the reset values above. Words already written stay in memory; nothing is erased.
- Width rules:
  - len is 16 bits and compared zero-extended.
  - word_cnt must hold 2**DEPTH, hence DEPTH+1 bits.
  - The highest mem_waddr used is 4*(2**DEPTH-1) = 0x3FC. mem_waddr never wraps within a load.

## Timing
- Minimum cost per word is 5 cycles: 4 byte cycles plus 1 WRITE cycle, with rx_valid held high.
- mem_we is high for exactly the cycle after the edge that consumed byte 3. mem_waddr and mem_wdata are stable for that whole cycle.
- rx_valid high during WRITE, IDLE, DONE or ERR consumes nothing. The byte stays pending until rx_ready returns.
- done rises, and cpu_hold falls, in the cycle after the final WRITE cycle.
- Minimum load time for N words: 1 (start) + 2 (header) + 5N cycles.
- Gaps in rx_valid stretch LEN0, LEN1 and DATA only, with no loss of state.

## Test plan
- Reset check: hold rst_n = 0 for 2 cycles and release -> all outputs match the reset values; rx_valid = 1 with no start causes no consumption.
- Two-word load: start, then bytes 02 00 13 01 50 00 93 01 C0 00 -> two writes:
  - 0x00500113 at address 0x0, then 0x00C00193 at 0x4, each with mem_we high for exactly 1 cycle;
  - afterwards done = 1, cpu_hold = 0, word_cnt = 2.
- Bad headers:
  - header 00 00 -> err = 1, cpu_hold = 1, no mem_we;
  - header 01 01 (len 257) -> err = 1;
  - start then header 01 00 plus 4 bytes -> err clears and the load completes.
- Backpressure: repeat the two-word load with rx_valid toggling every other cycle, and rx_valid held high through each WRITE cycle -> identical writes and no byte lost or duplicated.
- Reset mid-load: assert rst_n = 0 after 6 bytes (header plus 4 data bytes) -> state IDLE, cpu_hold = 1, exactly one write issued; a fresh load afterwards succeeds from address 0.
- Full memory and reload: load len 256 (header 00 01) -> last write at 0x3FC, word_cnt = 256, done = 1.
  - A start pulse in DATA is ignored.
  - A start pulse in DONE sets cpu_hold = 1 and done = 0 in the next cycle.

Source files
------------

// File: rtl/instr_mem_loader.sv
// instr_mem_loader: boot-time loader that fills instruction memory from a
// byte-serial stream and holds the core until the program is resident.
//
// Stream format: 16-bit little-endian word count, then 4 bytes per word.
// Each word is packed little-endian and written once at byte address 4*i.
//
// Ports:
//   clk, rst_n        system clock, synchronous active-low reset
//   start             single-cycle pulse that begins a load
//   rx_data/rx_valid  incoming byte stream
//   rx_ready          a byte can be consumed this cycle
//   mem_we/mem_waddr/mem_wdata   instruction memory write port
//   cpu_hold          keeps the core held; low only after a good load
//   done / err        load completed / length header rejected
//   word_cnt          words written in the current load
module instr_mem_loader #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [7:0]         rx_data,
    input  logic               rx_valid,
    output logic               rx_ready,
    output logic               mem_we,
    output logic [WIDTH-1:0]   mem_waddr,
    output logic [WIDTH-1:0]   mem_wdata,
    output logic               cpu_hold,
    output logic               done,
    output logic               err,
    output logic [DEPTH:0]     word_cnt
);

    localparam int unsigned CNT_W     = DEPTH + 1;
    localparam int unsigned MAX_WORDS = 1 << DEPTH;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LEN0  = 3'd1;
    localparam logic [2:0] S_LEN1  = 3'd2;
    localparam logic [2:0] S_DATA  = 3'd3;
    localparam logic [2:0] S_WRITE = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERR   = 3'd6;

    logic [2:0]       state, state_d;
    logic [7:0]       len_lo, len_lo_d;
    logic [15:0]      len, len_d;
    logic [15:0]      hdr_len;
    logic [1:0]       byte_idx, byte_idx_d;
    logic [WIDTH-1:0] waddr_d, wdata_d;
    logic [DEPTH:0]   cnt_d;
    logic             take;

    // rx_ready is a registered decode of state, so this is the consume strobe.
    assign take    = rx_valid && rx_ready;
    assign hdr_len = {rx_data, len_lo};

    // Next-state and datapath updates.
    always_comb begin
        state_d    = state;
        len_lo_d   = len_lo;
        len_d      = len;
        byte_idx_d = byte_idx;
        waddr_d    = mem_waddr;
        wdata_d    = mem_wdata;
        cnt_d      = word_cnt;
        case (state)
            S_IDLE: begin
                if (start) state_d = S_LEN0;
            end
            S_LEN0: begin
                if (take) begin
                    len_lo_d = rx_data;
                    state_d  = S_LEN1;
                end
            end
            S_LEN1: begin
                if (take) begin
                    len_d = hdr_len;
                    if (hdr_len == 16'd0 || 32'(hdr_len) > MAX_WORDS) begin
                        state_d = S_ERR;
                    end else begin
                        cnt_d      = '0;
                        waddr_d    = '0;
                        byte_idx_d = 2'd0;
                        state_d    = S_DATA;
                    end
                end
            end
            S_DATA: begin
                if (take) begin
                    case (byte_idx)
                        2'd0:    wdata_d[7:0]   = rx_data;
                        2'd1:    wdata_d[15:8]  = rx_data;
                        2'd2:    wdata_d[23:16] = rx_data;
                        default: wdata_d[31:24] = rx_data;
                    endcase
                    byte_idx_d = byte_idx + 2'd1;
                    if (byte_idx == 2'd3) state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                // Address and count advance on exit so they stay stable
                // for the whole write cycle.
                waddr_d = mem_waddr + WIDTH'(4);
                cnt_d   = word_cnt + CNT_W'(1);
                if (32'(cnt_d) == 32'(len)) state_d = S_DONE;
                else                        state_d = S_DATA;
            end
            S_DONE, S_ERR: begin
                if (start) state_d = S_LEN0;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, datapath and Moore outputs registered from the next state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            len_lo    <= '0;
            len       <= '0;
            byte_idx  <= '0;
            mem_waddr <= '0;
            mem_wdata <= '0;
            word_cnt  <= '0;
            rx_ready  <= 1'b0;
            mem_we    <= 1'b0;
            cpu_hold  <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_d;
            len_lo    <= len_lo_d;
            len       <= len_d;
            byte_idx  <= byte_idx_d;
            mem_waddr <= waddr_d;
            mem_wdata <= wdata_d;
            word_cnt  <= cnt_d;
            rx_ready  <= (state_d == S_LEN0) || (state_d == S_LEN1) ||
                         (state_d == S_DATA);
            mem_we    <= (state_d == S_WRITE);
            cpu_hold  <= (state_d != S_DONE);
            done      <= (state_d == S_DONE);
            err       <= (state_d == S_ERR);
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader: drives byte streams with and
// without gaps, captures every memory write and compares against writes
// derived directly from the stream contents.
module tb_instr_mem_loader;

    typedef logic [7:0] byte_q_t[$];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        mem_we;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;
    logic [8:0]  word_cnt;

    int errors = 0;
    int checks = 0;
    logic [63:0] got_q[$];

    instr_mem_loader #(.WIDTH(32), .DEPTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .cpu_hold(cpu_hold), .done(done), .err(err), .word_cnt(word_cnt)
    );

    always #5 clk = ~clk;

    // Every cycle with mem_we high is one write.
    always @(negedge clk) begin
        if (mem_we) got_q.push_back({mem_waddr, mem_wdata});
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rx_ready"}, 64'(rx_ready), 64'd0);
        chk({tag, "_mem_we"},   64'(mem_we),   64'd0);
        chk({tag, "_waddr"},    64'(mem_waddr), 64'd0);
        chk({tag, "_wdata"},    64'(mem_wdata), 64'd0);
        chk({tag, "_cpu_hold"}, 64'(cpu_hold), 64'd1);
        chk({tag, "_done"},     64'(done),     64'd0);
        chk({tag, "_err"},      64'(err),      64'd0);
        chk({tag, "_word_cnt"}, 64'(word_cnt), 64'd0);
    endtask

    // Present one byte, hold it until accepted; optionally pulse start with it.
    task automatic send_byte(input logic [7:0] b, input bit gap, input bit pulse);
        int n;
        if (gap && rx_ready) begin
            rx_valid = 1'b0;
            @(negedge clk);
        end
        rx_data  = b;
        rx_valid = 1'b1;
        if (pulse) start = 1'b1;
        n = 0;
        while (!rx_ready && n < 50) begin
            @(negedge clk);
            start = 1'b0;
            n++;
        end
        if (!rx_ready) chk("byte_accept", 64'(rx_ready), 64'd1);
        @(negedge clk);
        start = 1'b0;
    endtask

    // Run one load: start pulse, stream bytes, check outcome and writes.
    task automatic do_load(input string tag, input byte_q_t stream, input bit gap,
                           input int start_at, input int rst_after);
        logic [63:0] exp_q[$];
        int len, n_words, nsend;
        bit valid;
        got_q.delete();
        len   = int'({stream[1], stream[0]});
        valid = (len >= 1) && (len <= 256);
        if (!valid)              n_words = 0;
        else if (rst_after >= 0) n_words = (rst_after - 2) / 4;
        else                     n_words = len;
        for (int i = 0; i < n_words; i++) begin
            int k;
            k = 2 + 4 * i;
            exp_q.push_back({32'(4 * i), stream[k+3], stream[k+2], stream[k+1], stream[k]});
        end

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, "_len0_ready"}, 64'(rx_ready), 64'd1);
        chk({tag, "_len0_hold"},  64'(cpu_hold), 64'd1);
        chk({tag, "_len0_done"},  64'(done),     64'd0);
        chk({tag, "_len0_err"},   64'(err),      64'd0);

        if (rst_after >= 0) nsend = rst_after;
        else if (valid)     nsend = stream.size();
        else                nsend = 2;
        for (int i = 0; i < nsend; i++) send_byte(stream[i], gap, i == start_at);
        rx_valid = 1'b0;

        if (rst_after >= 0) begin
            rst_n = 1'b0;
            repeat (2) @(negedge clk);
            rst_n = 1'b1;
            @(negedge clk);
            check_reset_vals({tag, "_rst"});
        end else if (valid) begin
            chk({tag, "_last_we"}, 64'(mem_we), 64'd1);
            @(negedge clk);
            chk({tag, "_done"},     64'(done),     64'd1);
            chk({tag, "_hold"},     64'(cpu_hold), 64'd0);
            chk({tag, "_err"},      64'(err),      64'd0);
            chk({tag, "_word_cnt"}, 64'(word_cnt), 64'(len));
            chk({tag, "_we_off"},   64'(mem_we),   64'd0);
        end else begin
            chk({tag, "_err"},   64'(err),      64'd1);
            chk({tag, "_hold"},  64'(cpu_hold), 64'd1);
            chk({tag, "_done"},  64'(done),     64'd0);
            chk({tag, "_ready"}, 64'(rx_ready), 64'd0);
            @(negedge clk);
        end

        chk({tag, "_nwrites"}, 64'(got_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            if (got_q[i] !== exp_q[i]) chk({tag, "_write"}, got_q[i], exp_q[i]);
        end
        if (exp_q.size() > 0 && got_q.size() == exp_q.size())
            chk({tag, "_last_write"}, got_q[got_q.size()-1], exp_q[exp_q.size()-1]);
    endtask

    function automatic byte_q_t make_stream(input int len, input bit with_data);
        byte_q_t s;
        s.push_back(len[7:0]);
        s.push_back(len[15:8]);
        if (with_data)
            for (int i = 0; i < 4 * len; i++) s.push_back(8'($urandom_range(0, 255)));
        return s;
    endfunction

    initial begin
        byte_q_t two_word;
        byte_q_t s;
        two_word = '{8'h02, 8'h00, 8'h13, 8'h01, 8'h50, 8'h00, 8'h93, 8'h01, 8'hC0, 8'h00};

        // Reset, then a dangling rx_valid without start must be ignored.
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_reset_vals("reset");
        rx_data  = 8'hAA;
        rx_valid = 1'b1;
        repeat (3) @(negedge clk);
        chk("idle_no_ready", 64'(rx_ready), 64'd0);
        chk("idle_no_we",    64'(mem_we),   64'd0);
        rx_valid = 1'b0;

        do_load("two_word", two_word, 1'b0, -1, -1);
        do_load("two_word_gap", two_word, 1'b1, -1, -1);

        s = '{8'h00, 8'h00};
        do_load("len_zero", s, 1'b0, -1, -1);
        s = '{8'h01, 8'h01};
        do_load("len_257", s, 1'b0, -1, -1);
        s = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        do_load("len_one", s, 1'b0, -1, -1);

        do_load("mid_reset", two_word, 1'b0, -1, 6);
        do_load("after_reset", two_word, 1'b0, -1, -1);

        s = make_stream(256, 1'b1);
        do_load("full", s, 1'b0, 100, -1);
        s = make_stream(3, 1'b1);
        do_load("reload", s, 1'b0, -1, -1);

        for (int r = 0; r < 8; r++) begin
            int len;
            bit gap;
            gap = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 9) < 7) begin
                len = $urandom_range(1, 6);
                s = make_stream(len, 1'b1);
            end else begin
                len = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(257, 65535);
                s = make_stream(len, 1'b0);
            end
            do_load("random", s, gap, -1, -1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
